// File: rtl/fetch_stage.sv
// Fetch stage: PC register, PC+lookahead adder and IF/ID pipeline register with
// stall/flush/redirect handling and saturating stall/flush event counters.
module fetch_stage #(
    parameter int unsigned            WIDTH     = 32,
    parameter logic [WIDTH-1:0]       RESET_PC  = '0,
    parameter logic [WIDTH-1:0]       PC_STEP   = WIDTH'(32'd4),
    parameter logic [WIDTH-1:0]       LOOKAHEAD = WIDTH'(32'd8),
    parameter logic [WIDTH-1:0]       NOP_INSTR = '0,
    parameter int unsigned            CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             stall,
    input  logic             flush,
    input  logic [WIDTH-1:0] instr_f,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus8,
    output logic [WIDTH-1:0] instr_d,
    output logic [WIDTH-1:0] pc_d,
    output logic             valid_d,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    // Counters stick at all-ones rather than wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (&c) begin
            return c;
        end else begin
            return c + CNT_W'(1'b1);
        end
    endfunction

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_instr_d;
    logic [WIDTH-1:0] r_pc_d;
    logic             r_valid_d;
    logic [CNT_W-1:0] r_stall_count;
    logic [CNT_W-1:0] r_flush_count;

    logic [WIDTH-1:0] w_pc_next;
    logic [WIDTH-1:0] w_instr_d_next;
    logic [WIDTH-1:0] w_pc_d_next;
    logic             w_valid_d_next;
    logic             w_stall_ev;
    logic             w_flush_ev;

    // A redirect overrides a stall; a stall that loses to a redirect is not counted.
    assign w_stall_ev = stall & ~branch_taken;
    assign w_flush_ev = branch_taken | flush;

    // Next PC: redirect, hold, or sequential step.
    always_comb begin
        w_pc_next = r_pc;
        if (branch_taken) begin
            w_pc_next = branch_target;
        end else if (stall) begin
            w_pc_next = r_pc;
        end else begin
            w_pc_next = r_pc + PC_STEP;
        end
    end

    // Next IF/ID contents: bubble on flush/redirect (beats stall), hold on stall.
    always_comb begin
        w_instr_d_next = r_instr_d;
        w_pc_d_next    = r_pc_d;
        w_valid_d_next = r_valid_d;
        if (w_flush_ev) begin
            w_instr_d_next = NOP_INSTR;
            w_pc_d_next    = r_pc;
            w_valid_d_next = 1'b0;
        end else if (stall) begin
            w_instr_d_next = r_instr_d;
            w_pc_d_next    = r_pc_d;
            w_valid_d_next = r_valid_d;
        end else begin
            w_instr_d_next = instr_f;
            w_pc_d_next    = r_pc;
            w_valid_d_next = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_instr_d     <= NOP_INSTR;
            r_pc_d        <= '0;
            r_valid_d     <= 1'b0;
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            r_pc      <= w_pc_next;
            r_instr_d <= w_instr_d_next;
            r_pc_d    <= w_pc_d_next;
            r_valid_d <= w_valid_d_next;
            if (w_stall_ev) begin
                r_stall_count <= sat_inc(r_stall_count);
            end
            if (w_flush_ev) begin
                r_flush_count <= sat_inc(r_flush_count);
            end
        end
    end

    assign pc          = r_pc;
    assign pc_plus8    = r_pc + LOOKAHEAD;
    assign instr_d     = r_instr_d;
    assign pc_d        = r_pc_d;
    assign valid_d     = r_valid_d;
    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;

endmodule
